// File: rtl/add_mod_pipe.sv
// Two-stage streaming modular adder: out = (a + b) mod Q with valid/ready flow control
// and an end-of-polynomial marker on every LEN-th result.
module add_mod_pipe #(
   parameter int unsigned W   = 24,
   parameter int unsigned Q   = 12587009,
   parameter int unsigned LEN = 821
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   localparam int unsigned  CW       = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [W+1:0] QExt     = (W + 2)'(Q);
   localparam logic [CW-1:0] LastBeat = CW'(LEN - 1);

   logic          adv1, adv2;
   logic          v1_q, v2_q;
   logic [W:0]    sum1_q, sum1_d;
   logic [W-1:0]  r2_q, r2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W+1:0]  diff;
   logic          unused_diff_bit;

   always_comb begin
      adv2     = !v2_q || out_ready;
      adv1     = !v1_q || adv2;
      in_ready = adv1;

      sum1_d = {1'b0, a} + {1'b0, b};

      // Sign bit of the W+2-bit difference selects between sum and sum - Q.
      diff = {1'b0, sum1_q} - QExt;
      r2_d = diff[W+1] ? sum1_q[W-1:0] : diff[W-1:0];

      cnt_d = cnt_q;
      if (v2_q && out_ready) begin
         cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
      end
   end

   assign unused_diff_bit = diff[W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         sum1_q <= '0;
         r2_q   <= '0;
         cnt_q  <= '0;
      end else begin
         if (adv1) begin
            v1_q   <= in_valid;
            sum1_q <= sum1_d;
         end
         if (adv2) begin
            v2_q <= v1_q;
            r2_q <= r2_d;
         end
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = v2_q;
   assign out_data  = r2_q;
   assign out_last  = v2_q && (cnt_q == LastBeat);

endmodule

// File: tb/tb_add_mod_pipe.sv
// Self-checking bench for add_mod_pipe (LEN overridden to 4): in-order scoreboard with
// occupancy/latency model, plus directed vectors with literal expectations.
module tb_add_mod_pipe;

   localparam int unsigned W   = 24;
   localparam int unsigned Q   = 12587009;
   localparam int unsigned LEN = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;

   add_mod_pipe #(.W(W), .Q(Q), .LEN(LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int          nchk = 0;
   int          nerr = 0;
   int unsigned ecount = 0;
   int unsigned exp_q[$];
   int unsigned acc_q[$];
   int unsigned nout = 0;
   logic [W-1:0] got_data[$];
   logic         got_last[$];
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic         prev_last = 1'b0;
   bit           ready_mode = 1'b0;
   logic         ready_force = 1'b1;

   function automatic int unsigned mod_add(input int unsigned x, input int unsigned y);
      return (x + y) % Q;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   always @(posedge clk) ecount <= ecount + 1;

   // Consumer ready: either held by the main sequence or randomised.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // Scoreboard: FIFO of expected sums, each tagged with the edge it was accepted on.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         nout       = 0;
         prev_stall = 1'b0;
      end else begin
         logic exp_vis;
         exp_vis = (exp_q.size() > 0) && (ecount >= acc_q[0] + 1);
         check("out_valid", {31'b0, out_valid}, {31'b0, exp_vis});
         check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2) || out_ready});
         if (prev_stall) begin
            check("stall_data", {8'b0, out_data}, {8'b0, prev_data});
            check("stall_last", {31'b0, out_last}, {31'b0, prev_last});
         end
         if (out_valid && exp_vis) begin
            check("out_data", {8'b0, out_data}, exp_q[0]);
            check("out_last", {31'b0, out_last}, {31'b0, (nout % LEN) == LEN - 1});
         end
         if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            nout++;
            got_data.push_back(out_data);
            got_last.push_back(out_last);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(mod_add(a, b));
            acc_q.push_back(ecount + 1);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input int unsigned x, input int unsigned y);
      int guard = 0;
      a        = W'(x);
      b        = W'(y);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         nchk++;
         nerr++;
         $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", guard);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_out_data", {8'b0, out_data}, 0);
      check("rst_out_last", {31'b0, out_last}, 0);
      check("rst_in_ready", {31'b0, in_ready}, 1);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      got_data.delete();
      got_last.delete();
   endtask

   initial begin
      int unsigned lit_data[5];
      int unsigned x;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      #2;
      check("init_out_valid", {31'b0, out_valid}, 0);
      check("init_out_data", {8'b0, out_data}, 0);
      check("init_in_ready", {31'b0, in_ready}, 1);
      check("model_pin_wrap", mod_add(Q - 1, 1), 0);
      check("model_pin_max", mod_add(Q - 1, Q - 1), 12587007);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: accepted at edge k, visible after k+1.
      clear_logs();
      send(5, 7);
      @(negedge clk);
      check("lat_k1_valid", {31'b0, out_valid}, 0);
      @(negedge clk);
      check("lat_k2_valid", {31'b0, out_valid}, 1);
      check("lat_k2_data", {8'b0, out_data}, 12);
      @(posedge clk);
      #1;
      drain();

      // Basic and wrap-boundary sums.
      clear_logs();
      send(0, 0);
      send(5, 7);
      send(12587008, 1);
      send(12587008, 12587008);
      send(6293504, 6293504);
      drain();
      lit_data = '{0, 12, 0, 12587007, 12587008};
      check("basic_count", got_data.size(), 5);
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
         check($sformatf("basic_data[%0d]", i), {8'b0, got_data[i]}, lit_data[i]);
      end

      // Backpressure: two pairs fill the pipe, then a stalled third.
      clear_logs();
      ready_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(1, 2);
      send(2, 4);
      @(negedge clk);
      check("cap_in_ready", {31'b0, in_ready}, 0);
      check("cap_out_data", {8'b0, out_data}, 3);
      @(posedge clk);
      #1;
      fork
         send(3, 6);
         begin
            repeat (3) @(negedge clk);
            ready_force = 1'b1;
         end
      join
      send(4, 8);
      send(5, 10);
      drain();
      lit_data = '{3, 6, 9, 12, 15};
      check("bp_count", got_data.size(), 5);
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
         check($sformatf("bp_data[%0d]", i), {8'b0, got_data[i]}, lit_data[i]);
      end

      // out_last positions with LEN = 4, steady then random ready.
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         ready_mode = (pass == 1);
         clear_logs();
         for (int i = 1; i <= 10; i++) send(i, i);
         drain();
         ready_mode = 1'b0;
         check($sformatf("last_count_p%0d", pass), got_last.size(), 10);
         for (int i = 0; i < 10 && i < got_last.size(); i++) begin
            check($sformatf("last_p%0d[%0d]", pass, i), {31'b0, got_last[i]},
                  {31'b0, (i == 3) || (i == 7)});
         end
      end

      // Reset mid-stream with two pairs in flight.
      ready_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(100, 200);
      send(300, 400);
      do_reset();
      ready_force = 1'b1;
      clear_logs();
      for (int i = 1; i <= 4; i++) send(10 * i, 1);
      drain();
      check("rst_count", got_last.size(), 4);
      for (int i = 0; i < 4 && i < got_last.size(); i++) begin
         check($sformatf("rst_last[%0d]", i), {31'b0, got_last[i]}, {31'b0, i == 3});
         check($sformatf("rst_data[%0d]", i), {8'b0, got_data[i]}, 10 * (i + 1) + 1);
      end

      // Random soak, in-range operands, random gaps and backpressure.
      ready_mode = 1'b1;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         x = $urandom_range(0, 7) == 0 ? Q - 1 : $urandom_range(0, Q - 1);
         send(x, $urandom_range(0, Q - 1));
      end
      drain();
      ready_mode = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", nerr);
      $fatal(1);
   end

endmodule
